perf_monitor: RTL and testbench

PERF_MONITOR -- requirements
Module: perf_monitor

---
 rtl/perf_monitor.sv | 146 ++++++++++++++
 tb/tb_perf_monitor.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_monitor.sv
// perf_monitor: run-length performance counter block.
// Counts cycles and per-channel event strobes while the run FSM sits in RUN,
// saturating each counter and flagging saturation with a sticky bit.
// Optional feature macro: PERF_MONITOR_SNAPSHOT_EN adds snap_i and a shadow
// bank that rd_data_o reads instead of the live counters.
module perf_monitor #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned NUM_EV     = 2,
  parameter int unsigned MAX_CYCLES = 30,
  parameter int unsigned SEL_W      = $clog2(NUM_EV + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              clear_i,
`ifdef PERF_MONITOR_SNAPSHOT_EN
  input  logic              snap_i,
`endif
  input  logic [NUM_EV-1:0] event_i,
  input  logic [SEL_W-1:0]  rd_sel_i,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic [1:0]        state_o,
  output logic              done_o,
  output logic [NUM_EV:0]   ovf_o
);

  localparam int unsigned     NUM_CNT = NUM_EV + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ST_ILL is never entered; it exists so the encoding space is fully named
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10,
    ST_ILL  = 2'b11
  } state_e;

  state_e                          state_q, state_d;
  logic [NUM_CNT-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CNT-1:0]              ovf_q, ovf_d;
  logic [NUM_CNT-1:0]              inc;
  logic                            limit_hit;

  // Index 0 is the cycle counter and always increments in RUN
  assign inc = {event_i, 1'b1};

  // Next-state, counter and sticky-flag computation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    limit_hit = 1'b0;
    if (clear_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ovf_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < int'(NUM_CNT); i++) begin
            if (inc[i]) begin
              if (cnt_q[i] == CNT_MAX) begin
                ovf_d[i] = 1'b1;
              end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
              end
            end
          end
          // Compare at 64 bits so a limit wider than the counter never aliases
          limit_hit = (MAX_CYCLES != 0) && (64'(cnt_d[0]) == 64'(MAX_CYCLES));
          if (limit_hit) begin
            state_d = ST_DONE;
          end else if (!start_i) begin
            state_d = ST_IDLE;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

`ifdef PERF_MONITOR_SNAPSHOT_EN
  logic [NUM_CNT-1:0][CNT_W-1:0] shadow_q, shadow_d;

  // Shadow capture takes this edge's counter update, so snapshots include it
  always_comb begin
    shadow_d = shadow_q;
    if (clear_i) begin
      shadow_d = '0;
    end else if (snap_i) begin
      shadow_d = cnt_d;
    end
  end

  // Shadow bank register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`endif

  // FSM, counter and flag registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Read mux; selects beyond the last counter return zero
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < int'(NUM_CNT); i++) begin
      if (rd_sel_i == SEL_W'(i)) begin
`ifdef PERF_MONITOR_SNAPSHOT_EN
        rd_data_o = shadow_q[i];
`else
        rd_data_o = cnt_q[i];
`endif
      end
    end
  end

  assign state_o = state_q;
  assign done_o  = (state_q == ST_DONE);
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Self-checking bench for perf_monitor: two instances (8-bit/limit 30 and
// 4-bit/unlimited) share stimulus and are checked against a per-instance
// behavioural model of the counting rules.
module tb_perf_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       clear;
  logic       snap;
  logic [1:0] ev;
  logic [1:0] sel;

  logic [7:0] rd_a;
  logic [3:0] rd_b;
  logic [1:0] st_a, st_b;
  logic       done_a, done_b;
  logic [2:0] ovf_a, ovf_b;

  int errors = 0;
  int checks = 0;

  // Behavioural model, index 0 = dut_a, 1 = dut_b
  int m_w[2]   = '{8, 4};
  int m_max[2] = '{30, 0};
  int m_cnt[2][3];
  int m_sh[2][3];
  int m_ovf[2][3];
  int m_st[2];  // 0 idle, 1 run, 2 done

  always #5 clk = ~clk;

  perf_monitor #(.CNT_W(8), .NUM_EV(2), .MAX_CYCLES(30)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
`ifdef PERF_MONITOR_SNAPSHOT_EN
    .snap_i(snap),
`endif
    .event_i(ev), .rd_sel_i(sel), .rd_data_o(rd_a), .state_o(st_a),
    .done_o(done_a), .ovf_o(ovf_a)
  );

  perf_monitor #(.CNT_W(4), .NUM_EV(2), .MAX_CYCLES(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
`ifdef PERF_MONITOR_SNAPSHOT_EN
    .snap_i(snap),
`endif
    .event_i(ev), .rd_sel_i(sel), .rd_data_o(rd_b), .state_o(st_b),
    .done_o(done_b), .ovf_o(ovf_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_st[d] = 0;
      for (int c = 0; c < 3; c++) begin
        m_cnt[d][c] = 0;
        m_sh[d][c]  = 0;
        m_ovf[d][c] = 0;
      end
    end
  endtask

  // Apply one rising edge's worth of behaviour to the model
  task automatic model_edge();
    bit snap_eff;
`ifdef PERF_MONITOR_SNAPSHOT_EN
    snap_eff = snap;
`else
    snap_eff = 1'b0;
`endif
    for (int d = 0; d < 2; d++) begin
      if (clear) begin
        m_st[d] = 0;
        for (int c = 0; c < 3; c++) begin
          m_cnt[d][c] = 0;
          m_ovf[d][c] = 0;
          m_sh[d][c]  = 0;
        end
      end else begin
        if (m_st[d] == 1) begin
          for (int c = 0; c < 3; c++) begin
            if (c == 0 || ev[c-1]) begin
              if (m_cnt[d][c] == (1 << m_w[d]) - 1) m_ovf[d][c] = 1;
              else m_cnt[d][c] = m_cnt[d][c] + 1;
            end
          end
          if (m_max[d] != 0 && m_cnt[d][0] == m_max[d]) m_st[d] = 2;
          else if (!start) m_st[d] = 0;
        end else if (m_st[d] == 0 && start) begin
          m_st[d] = 1;
        end
        if (snap_eff) begin
          for (int c = 0; c < 3; c++) m_sh[d][c] = m_cnt[d][c];
        end
      end
    end
  endtask

  function automatic int model_rd(input int d, input int s);
    if (s > 2) return 0;
`ifdef PERF_MONITOR_SNAPSHOT_EN
    return m_sh[d][s];
`else
    return m_cnt[d][s];
`endif
  endfunction

  // Compare every observable output of both instances against the model
  task automatic check_all(input string tag);
    chk({tag, "_st_a"},   32'(st_a),   32'(m_st[0]));
    chk({tag, "_st_b"},   32'(st_b),   32'(m_st[1]));
    chk({tag, "_done_a"}, 32'(done_a), 32'(m_st[0] == 2));
    chk({tag, "_done_b"}, 32'(done_b), 32'(m_st[1] == 2));
    chk({tag, "_ovf_a"},  32'(ovf_a),  32'(m_ovf[0][2] * 4 + m_ovf[0][1] * 2 + m_ovf[0][0]));
    chk({tag, "_ovf_b"},  32'(ovf_b),  32'(m_ovf[1][2] * 4 + m_ovf[1][1] * 2 + m_ovf[1][0]));
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk($sformatf("%s_rd_a%0d", tag, s), 32'(rd_a), 32'(model_rd(0, s)));
      chk($sformatf("%s_rd_b%0d", tag, s), 32'(rd_b), 32'(model_rd(1, s)));
    end
  endtask

  // One clock edge, model update, then full comparison (ends at the falling edge)
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic read_sel(input int s);
    sel = 2'(s);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; snap = 1'b0; ev = 2'b00; sel = 2'd0;
    model_reset();
    @(negedge clk);
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Free run to the limit with no events
    start = 1'b1;
    repeat (31) tick("run30");
    read_sel(0);
    chk("limit_state_a", 32'(st_a), 32'd2);
    chk("limit_done_a",  32'(done_a), 32'd1);
    chk("limit_cyc_a",   32'(rd_a), 32'd30);
    chk("sat_cyc_b",     32'(rd_b), 32'd15);
    chk("sat_ovf0_b",    32'(ovf_b[0]), 32'd1);
    chk("sat_state_b",   32'(st_b), 32'd1);
    repeat (10) tick("hold");
    read_sel(0);
    chk("hold_cyc_a",   32'(rd_a), 32'd30);
    chk("hold_state_a", 32'(st_a), 32'd2);

    // Clear beats start and events on the same edge
    ev = 2'b11; clear = 1'b1;
    tick("clr");
    clear = 1'b0; ev = 2'b00;
    chk("clr_state_a", 32'(st_a), 32'd0);
    chk("clr_ovf_b",   32'(ovf_b), 32'd0);
    read_sel(3);
    chk("clr_sel3_a",  32'(rd_a), 32'd0);
    read_sel(1);
    chk("clr_sel1_a",  32'(rd_a), 32'd0);

    // Simultaneous and single-channel events
    tick("ev_go");
    ev = 2'b11;
    repeat (10) tick("ev11");
    ev = 2'b01;
    repeat (5) tick("ev01");
    ev = 2'b00;
    read_sel(1);
    chk("stall_a", 32'(rd_a), 32'd15);
    chk("stall_b", 32'(rd_b), 32'd15);
    read_sel(2);
    chk("flush_a", 32'(rd_a), 32'd10);
    chk("flush_b", 32'(rd_b), 32'd10);

    // Pause at 12 and resume to the limit
    clear = 1'b1; tick("pclr"); clear = 1'b0;
    tick("pgo");
    repeat (11) tick("prun");
    start = 1'b0;
    tick("pstop");
    read_sel(0);
    chk("pause_state_a", 32'(st_a), 32'd0);
    chk("pause_cyc_a",   32'(rd_a), 32'd12);
    repeat (5) tick("pidle");
    read_sel(0);
    chk("frozen_cyc_a", 32'(rd_a), 32'd12);
    start = 1'b1;
    for (int n = 0; n < 40 && !done_a; n++) tick("resume");
    read_sel(0);
    chk("resume_done_a", 32'(done_a), 32'd1);
    chk("resume_cyc_a",  32'(rd_a), 32'd30);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      start = ($urandom_range(0, 9) != 0);
      ev    = 2'($urandom);
      clear = ($urandom_range(0, 39) == 0);
      snap  = ($urandom_range(0, 7) == 0);
      tick("rand");
    end
    clear = 1'b0; snap = 1'b0; ev = 2'b00;

    // Asynchronous reset between edges mid-run
    clear = 1'b1; tick("rclr"); clear = 1'b0;
    start = 1'b1;
    repeat (6) tick("rrun");
    sel = 2'd0;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_state_a", 32'(st_a), 32'd0);
    chk("arst_state_b", 32'(st_b), 32'd0);
    chk("arst_done_a",  32'(done_a), 32'd0);
    chk("arst_ovf_b",   32'(ovf_b), 32'd0);
    chk("arst_rd_a",    32'(rd_a), 32'd0);
    chk("arst_rd_b",    32'(rd_b), 32'd0);
    #1;
    rst = 1'b0;
    start = 1'b0;
    repeat (3) tick("rwait");
    chk("rwait_state_a", 32'(st_a), 32'd0);

`ifdef PERF_MONITOR_SNAPSHOT_EN
    // Snapshot at count 7, then keep running
    start = 1'b1;
    tick("sgo");
    repeat (6) tick("srun");
    snap = 1'b1;
    tick("ssnap");
    snap = 1'b0;
    repeat (5) tick("spost");
    read_sel(0);
    chk("snap_rd_a", 32'(rd_a), 32'd7);
    chk("snap_rd_b", 32'(rd_b), 32'd7);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
